// File: rtl/filter_pkg.sv
// filter_pkg: shared state type and sizing helpers for the moving-average filter
package filter_pkg;
  typedef enum logic {FILL, RUN} state_e;
  function automatic int window_depth(input int wl2);
    return 1 << wl2;
  endfunction
  function automatic int sum_width(input int dw, input int wl2);
    return dw + wl2;
  endfunction
endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered rising-edge detector for a single flag
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic flag_i,
  output logic rise_o
);
  logic flag_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flag_q <= 1'b0;
    else flag_q <= flag_i;
  assign rise_o = flag_i & ~flag_q;
endmodule

// File: rtl/moving_average_filter.sv
// moving_average_filter: running mean over the last 2**WINDOW_LOG2 valid samples with invalid-transfer counter
module moving_average_filter
  import filter_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int WINDOW_LOG2 = 2,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  input  logic                  data_invalid_in,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] avg_out,
  output logic                  avg_valid,
  output logic                  window_full,
  output logic [ERR_WIDTH-1:0]  err_count
);
  localparam int DEPTH = window_depth(WINDOW_LOG2);
  localparam int SW    = sum_width(DATA_WIDTH, WINDOW_LOG2);
  localparam int FW    = WINDOW_LOG2 + 1;

  logic                   v_rise, i_rise, accept, full_after;
  logic [DATA_WIDTH-1:0]  win_q [DEPTH];
  logic [SW-1:0]          sum_q, sum_d;
  logic [WINDOW_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic                   pend_q, pend_d, avg_valid_q, avg_valid_d;
  logic [DATA_WIDTH-1:0]  avg_q, avg_d;
  logic [ERR_WIDTH-1:0]   err_q, err_d;
  state_e                 state_q, state_d;

  rise_detect u_valid (.clk(clk), .rst_n(reset_n), .flag_i(data_valid_in), .rise_o(v_rise));
  rise_detect u_inval (.clk(clk), .rst_n(reset_n), .flag_i(data_invalid_in), .rise_o(i_rise));

  // invalid beats valid, flush beats both for the window
  assign accept     = v_rise & ~i_rise & ~flush;
  assign full_after = (state_q == RUN) || (fill_q == FW'(DEPTH - 1));

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= FILL;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (flush) state_d = FILL;
    else if (accept && full_after) state_d = RUN;
  end

  always_comb window_full = (state_q == RUN);

  always_comb begin
    sum_d       = flush ? '0 : accept ? sum_q + SW'(data_in) - SW'(win_q[wr_ptr_q]) : sum_q;
    wr_ptr_d    = flush ? '0 : accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    fill_d      = flush ? '0 : (accept && state_q == FILL) ? fill_q + 1'b1 : fill_q;
    pend_d      = accept && full_after;
    avg_valid_d = pend_q;
    avg_d       = pend_q ? sum_q[SW-1:WINDOW_LOG2] : avg_q;
    err_d       = (i_rise && err_q != '1) ? err_q + 1'b1 : err_q;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      pend_q      <= 1'b0;
      avg_valid_q <= 1'b0;
      avg_q       <= '0;
      err_q       <= '0;
    end else begin
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      pend_q      <= pend_d;
      avg_valid_q <= avg_valid_d;
      avg_q       <= avg_d;
      err_q       <= err_d;
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) win_q <= '{default: '0};
    else if (flush) win_q <= '{default: '0};
    else if (accept) win_q[wr_ptr_q] <= data_in;

  assign avg_out   = avg_q;
  assign avg_valid = avg_valid_q;
  assign err_count = err_q;
endmodule
